// File: rtl/config_loader.sv
// -----------------------------------------------------------------------------
// config_loader
//
// Frame-based configuration controller for the add/multiplex/shift fabric.
// A frame of 15 configuration words (plus a trailing XOR checksum word when
// CHECK_EN != 0) is received into a shadow buffer. Once the frame has been
// verified, the shadow buffer is written into the fabric in a fixed,
// uninterruptible sequence: six LUT-class writes followed by three switch-box
// writes.
//
// Frame layout (word index):
//   0..11  (LUT, mux) pairs for classes ADD0, ADD1, ADDC, MUX, MUXS, REGC
//   12     SB0 configuration
//   13     SB1/SB2 configuration (broadcast)
//   14     SB3 configuration
//   15     XOR of words 0..14 (only when CHECK_EN != 0)
//
// Ports:
//   clock       in   system clock, all state changes on the rising edge
//   reset       in   synchronous, active-high
//   start       in   one-cycle pulse, begins (or restarts) a frame
//   cfg_data    in   32-bit configuration word
//   cfg_valid   in   cfg_data is valid
//   cfg_ready   out  loader accepts a word
//   lut_wdata   out  {mux control bit, 32-bit LUT}
//   lut_class   out  LUT class being written (0 ADD0 .. 5 REGC)
//   lut_we      out  LUT write strobe, one cycle per class
//   sb_wdata    out  16-bit switch-box configuration
//   sb_sel      out  0 = SB0, 1 = SB1+SB2, 2 = SB3
//   sb_we       out  switch-box write strobe
//   busy        out  high in RECV, CHECK and COMMIT
//   done        out  frame committed; held until next start or reset
//   error       out  checksum mismatch; held until next start or reset
//   state_dbg   out  current FSM state (IDLE=0 RECV=1 CHECK=2 COMMIT=3
//                    DONE=4 ERR=5)
//
// Handshake: a word transfers on a rising edge where cfg_valid & cfg_ready
// are both high. cfg_ready is decoded from the state register only, so it
// never depends on cfg_valid; the source may hold cfg_valid high for as long
// as it likes and words outside RECV are simply not taken.
// -----------------------------------------------------------------------------
module config_loader #(
    parameter int CHECK_EN = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] cfg_data,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    output logic [32:0] lut_wdata,
    output logic [2:0]  lut_class,
    output logic        lut_we,
    output logic [15:0] sb_wdata,
    output logic [1:0]  sb_sel,
    output logic        sb_we,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RECV   = 3'd1,
        S_CHECK  = 3'd2,
        S_COMMIT = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    // Index of the word whose transfer ends the frame.
    localparam logic [4:0] LAST_IDX = (CHECK_EN != 0) ? 5'd15 : 5'd14;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [31:0] xor_q, xor_d;
    logic [3:0]  cidx_q, cidx_d;
    logic [31:0] shadow_q [15];
    logic [31:0] shadow_d [15];

    logic        lut_we_q, lut_we_d;
    logic [2:0]  lut_class_q, lut_class_d;
    logic [32:0] lut_wdata_q, lut_wdata_d;
    logic        sb_we_q, sb_we_d;
    logic [1:0]  sb_sel_q, sb_sel_d;
    logic [15:0] sb_wdata_q, sb_wdata_d;
    logic        done_q, done_d;
    logic        error_q, error_d;

    logic        start_ok;
    logic        chk_pass;
    logic [3:0]  lut_lo;
    logic [3:0]  lut_hi;
    logic [3:0]  sb_idx;

    // ---------------------------------------------------------------------
    // Next-state, datapath and registered-output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        xor_d    = xor_q;
        cidx_d   = cidx_q;
        shadow_d = shadow_q;

        // start is honoured everywhere except CHECK and COMMIT, which keeps
        // the write-out atomic. In RECV it aborts and restarts the frame,
        // and it takes precedence over a coincident transfer.
        start_ok = start && (state_q == S_IDLE || state_q == S_RECV ||
                             state_q == S_DONE || state_q == S_ERR);

        // With the checksum word folded into the running XOR, a good frame
        // leaves the accumulator at zero.
        chk_pass = (CHECK_EN == 0) || (xor_q == 32'd0);

        if (start_ok) begin
            state_d = S_RECV;
            idx_d   = 5'd0;
            xor_d   = 32'd0;
        end else begin
            case (state_q)
                S_RECV: begin
                    if (cfg_valid) begin
                        // The checksum word (index 15) is not stored.
                        if (idx_q < 5'd15) begin
                            shadow_d[idx_q[3:0]] = cfg_data;
                        end
                        xor_d = xor_q ^ cfg_data;
                        idx_d = idx_q + 5'd1;
                        if (idx_q == LAST_IDX) begin
                            state_d = S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    cidx_d  = 4'd0;
                    state_d = chk_pass ? S_COMMIT : S_ERR;
                end
                S_COMMIT: begin
                    cidx_d = cidx_q + 4'd1;
                    if (cidx_q == 4'd8) begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                end
            endcase
        end

        // Commit write-out. Strobe/data/select registers are loaded from the
        // current commit index, so each write appears one cycle after the
        // state register reaches that step.
        lut_lo = {cidx_q[2:0], 1'b0};
        lut_hi = {cidx_q[2:0], 1'b1};
        sb_idx = cidx_q + 4'd6;

        lut_we_d    = 1'b0;
        lut_class_d = 3'd0;
        lut_wdata_d = 33'd0;
        sb_we_d     = 1'b0;
        sb_sel_d    = 2'd0;
        sb_wdata_d  = 16'd0;

        if (state_q == S_COMMIT) begin
            if (cidx_q < 4'd6) begin
                lut_we_d    = 1'b1;
                lut_class_d = cidx_q[2:0];
                lut_wdata_d = {shadow_q[lut_hi][0], shadow_q[lut_lo]};
            end else begin
                sb_we_d    = 1'b1;
                // cidx 6,7,8 -> select 0,1,2 (modulo-4 subtraction)
                sb_sel_d   = cidx_q[1:0] - 2'd2;
                sb_wdata_d = shadow_q[sb_idx][15:0];
            end
        end

        done_d  = start_ok ? 1'b0 : (done_q  | (state_q == S_DONE));
        error_d = start_ok ? 1'b0 : (error_q | (state_q == S_ERR));
    end

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 5'd0;
            xor_q       <= 32'd0;
            cidx_q      <= 4'd0;
            lut_we_q    <= 1'b0;
            lut_class_q <= 3'd0;
            lut_wdata_q <= 33'd0;
            sb_we_q     <= 1'b0;
            sb_sel_q    <= 2'd0;
            sb_wdata_q  <= 16'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            xor_q       <= xor_d;
            cidx_q      <= cidx_d;
            lut_we_q    <= lut_we_d;
            lut_class_q <= lut_class_d;
            lut_wdata_q <= lut_wdata_d;
            sb_we_q     <= sb_we_d;
            sb_sel_q    <= sb_sel_d;
            sb_wdata_q  <= sb_wdata_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Shadow buffer holds frame data only; every commit is preceded by a
    // complete reload, so it needs no reset.
    always_ff @(posedge clock) begin
        shadow_q <= shadow_d;
    end

    assign cfg_ready = (state_q == S_RECV);
    assign busy      = (state_q == S_RECV) || (state_q == S_CHECK) ||
                       (state_q == S_COMMIT);
    assign lut_we    = lut_we_q;
    assign lut_class = lut_class_q;
    assign lut_wdata = lut_wdata_q;
    assign sb_we     = sb_we_q;
    assign sb_sel    = sb_sel_q;
    assign sb_wdata  = sb_wdata_q;
    assign done      = done_q;
    assign error     = error_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_config_loader.sv
// -----------------------------------------------------------------------------
// tb_config_loader
//
// Drives two loaders from one input stream: u_dut_a with the checksum word
// (CHECK_EN = 1) and u_dut_b without it (CHECK_EN = 0). A per-instance frame
// model predicts every output on every cycle from the frame rules (final
// transfer cycle k, writes at k+2..k+10, done from k+11, error from k+2).
// Directed scenarios add literal expectations that pin the model.
// -----------------------------------------------------------------------------
module tb_config_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] cfg_data;
    logic        cfg_valid;

    logic        a_cfg_ready, b_cfg_ready;
    logic [32:0] a_lut_wdata, b_lut_wdata;
    logic [2:0]  a_lut_class, b_lut_class;
    logic        a_lut_we, b_lut_we;
    logic [15:0] a_sb_wdata, b_sb_wdata;
    logic [1:0]  a_sb_sel, b_sb_sel;
    logic        a_sb_we, b_sb_we;
    logic        a_busy, b_busy;
    logic        a_done, b_done;
    logic        a_error, b_error;
    logic [2:0]  a_state_dbg, b_state_dbg;

    config_loader #(.CHECK_EN(1)) u_dut_a (
        .clock(clock), .reset(reset), .start(start),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(a_cfg_ready),
        .lut_wdata(a_lut_wdata), .lut_class(a_lut_class), .lut_we(a_lut_we),
        .sb_wdata(a_sb_wdata), .sb_sel(a_sb_sel), .sb_we(a_sb_we),
        .busy(a_busy), .done(a_done), .error(a_error), .state_dbg(a_state_dbg)
    );

    config_loader #(.CHECK_EN(0)) u_dut_b (
        .clock(clock), .reset(reset), .start(start),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(b_cfg_ready),
        .lut_wdata(b_lut_wdata), .lut_class(b_lut_class), .lut_we(b_lut_we),
        .sb_wdata(b_sb_wdata), .sb_sel(b_sb_sel), .sb_we(b_sb_we),
        .busy(b_busy), .done(b_done), .error(b_error), .state_dbg(b_state_dbg)
    );

    // ---------------------------------------------------------------------
    // Clock
    // ---------------------------------------------------------------------
    always #5 clock = ~clock;

    // ---------------------------------------------------------------------
    // Check bookkeeping
    // ---------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;
    bit armed    = 1'b0;

    task automatic check(input string name, input logic [32:0] act,
                         input logic [32:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // ---------------------------------------------------------------------
    // Frame model (index 0 = CHECK_EN 1, index 1 = CHECK_EN 0)
    // ---------------------------------------------------------------------
    int          cyc = 0;
    bit          m_recv [2];
    int          m_cnt  [2];
    int          m_k    [2];   // edge of the final transfer, -1 if none
    bit          m_pass [2];
    logic [31:0] m_w    [2][16];

    function automatic logic [31:0] model_xor15(input int i);
        logic [31:0] x = 32'd0;
        for (int n = 0; n < 15; n++) x = x ^ m_w[i][n];
        return x;
    endfunction

    task automatic model_step(input int i);
        int d;
        bit locked;
        if (reset) begin
            m_recv[i] = 1'b0;
            m_cnt[i]  = 0;
            m_k[i]    = -1;
            return;
        end
        d = cyc - m_k[i];
        // start is ignored while the frame is being checked or committed
        locked = (m_k[i] >= 0) && (m_pass[i] ? (d >= 1 && d <= 10) : (d == 1));
        if (start && !locked) begin
            m_recv[i] = 1'b1;
            m_cnt[i]  = 0;
            m_k[i]    = -1;
        end else if (m_recv[i] && cfg_valid) begin
            m_w[i][m_cnt[i]] = cfg_data;
            m_cnt[i]++;
            if (m_cnt[i] == ((i == 0) ? 16 : 15)) begin
                m_recv[i] = 1'b0;
                m_k[i]    = cyc;
                m_pass[i] = (i == 1) || (model_xor15(i) == m_w[i][15]);
            end
        end
    endtask

    task automatic compare_inst(input int i, input string p,
                                input logic rdy, input logic bsy,
                                input logic lwe, input logic [2:0] lcls,
                                input logic [32:0] lwd, input logic swe,
                                input logic [1:0] ssel, input logic [15:0] swd,
                                input logic dn, input logic er);
        int d;
        bit fr;
        logic        e_lwe, e_swe, e_bsy, e_dn, e_er;
        logic [2:0]  e_cls;
        logic [32:0] e_lwd;
        logic [1:0]  e_sel;
        logic [15:0] e_swd;
        fr    = (m_k[i] >= 0);
        d     = cyc - m_k[i];
        e_lwe = fr && m_pass[i] && d >= 2 && d <= 7;
        e_swe = fr && m_pass[i] && d >= 8 && d <= 10;
        e_dn  = fr && m_pass[i] && d >= 11;
        e_er  = fr && !m_pass[i] && d >= 2;
        e_bsy = m_recv[i] || (fr && (m_pass[i] ? d <= 9 : d == 0));
        e_cls = 3'd0;
        e_lwd = 33'd0;
        e_sel = 2'd0;
        e_swd = 16'd0;
        if (e_lwe) begin
            e_cls = 3'(d - 2);
            e_lwd = {m_w[i][2 * (d - 2) + 1][0], m_w[i][2 * (d - 2)]};
        end
        if (e_swe) begin
            e_sel = 2'(d - 8);
            e_swd = m_w[i][12 + d - 8][15:0];
        end
        check({p, ".cfg_ready"}, 33'(rdy),  33'(m_recv[i]));
        check({p, ".busy"},      33'(bsy),  33'(e_bsy));
        check({p, ".lut_we"},    33'(lwe),  33'(e_lwe));
        check({p, ".lut_class"}, 33'(lcls), 33'(e_cls));
        check({p, ".lut_wdata"}, lwd,       e_lwd);
        check({p, ".sb_we"},     33'(swe),  33'(e_swe));
        check({p, ".sb_sel"},    33'(ssel), 33'(e_sel));
        check({p, ".sb_wdata"},  33'(swd),  33'(e_swd));
        check({p, ".done"},      33'(dn),   33'(e_dn));
        check({p, ".error"},     33'(er),   33'(e_er));
    endtask

    // Model advances on each rising edge; outputs are compared 1 ns later.
    always @(posedge clock) begin
        cyc++;
        model_step(0);
        model_step(1);
        #1;
        if (armed) begin
            compare_inst(0, "a", a_cfg_ready, a_busy, a_lut_we, a_lut_class,
                         a_lut_wdata, a_sb_we, a_sb_sel, a_sb_wdata, a_done, a_error);
            compare_inst(1, "b", b_cfg_ready, b_busy, b_lut_we, b_lut_class,
                         b_lut_wdata, b_sb_we, b_sb_sel, b_sb_wdata, b_done, b_error);
        end
    end

    // ---------------------------------------------------------------------
    // Stimulus data and driver tasks (inputs change on the falling edge)
    // ---------------------------------------------------------------------
    logic [31:0] frame_a [16];
    logic [31:0] frame_b [16];
    logic [31:0] tx      [16];

    // Per-cycle samples taken by watch(); index j = cycles after the final
    // transfer edge of the frame just sent.
    logic        s_a_lwe [16], s_a_swe [16], s_a_dn [16], s_a_er [16], s_a_rdy [16];
    logic [32:0] s_a_lwd [16];
    logic [2:0]  s_a_cls [16];
    logic [1:0]  s_a_sel [16];
    logic        s_b_lwe [16], s_b_dn [16], s_b_rdy [16];
    logic [32:0] s_b_lwd [16];

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_words(input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap) begin
                cfg_valid = 1'b0;
                cfg_data  = $urandom;
                @(negedge clock);
            end
            cfg_valid = 1'b1;
            cfg_data  = tx[i];
            @(negedge clock);
        end
        cfg_valid = 1'b0;
        cfg_data  = 32'd0;
    endtask

    task automatic watch(input int len);
        for (int j = 0; j < len; j++) begin
            s_a_lwe[j] = a_lut_we;   s_a_swe[j] = a_sb_we;
            s_a_dn[j]  = a_done;     s_a_er[j]  = a_error;
            s_a_rdy[j] = a_cfg_ready;
            s_a_lwd[j] = a_lut_wdata; s_a_cls[j] = a_lut_class;
            s_a_sel[j] = a_sb_sel;
            s_b_lwe[j] = b_lut_we;   s_b_dn[j]  = b_done;
            s_b_rdy[j] = b_cfg_ready; s_b_lwd[j] = b_lut_wdata;
            @(negedge clock);
        end
    endtask

    function automatic int count_bits(input int sel, input int len);
        int c = 0;
        for (int j = 0; j < len; j++) begin
            case (sel)
                0: c += int'(s_a_lwe[j]);
                1: c += int'(s_a_swe[j]);
                2: c += int'(s_b_lwe[j]);
                default: c += int'(s_b_rdy[j]);
            endcase
        end
        return c;
    endfunction

    task automatic load_tx(input bit use_b);
        for (int i = 0; i < 16; i++) tx[i] = use_b ? frame_b[i] : frame_a[i];
    endtask

    // Literal checks shared by every good CHECK_EN=1 frame of frame_a.
    task automatic check_good_a(input string tag);
        check({tag, ".lut_we@k+2"},   33'(s_a_lwe[2]), 33'd1);
        check({tag, ".lut_we@k+1"},   33'(s_a_lwe[1]), 33'd0);
        check({tag, ".lut_wdata0"},   s_a_lwd[2], 33'h1_96696996);
        check({tag, ".lut_class0"},   33'(s_a_cls[2]), 33'd0);
        check({tag, ".lut_pulses"},   33'(count_bits(0, 14)), 33'd6);
        check({tag, ".sb_pulses"},    33'(count_bits(1, 14)), 33'd3);
        for (int n = 0; n < 3; n++)
            check({tag, ".sb_sel_order"}, 33'(s_a_sel[8 + n]), 33'(n));
        check({tag, ".done@k+10"},    33'(s_a_dn[10]), 33'd0);
        check({tag, ".done@k+11"},    33'(s_a_dn[11]), 33'd1);
    endtask

    // ---------------------------------------------------------------------
    // Directed scenarios
    // ---------------------------------------------------------------------
    initial begin
        logic [31:0] x;
        for (int i = 0; i < 2; i++) begin
            m_recv[i] = 1'b0; m_cnt[i] = 0; m_k[i] = -1; m_pass[i] = 1'b0;
        end
        // frame_a: word0/word1 fixed, mux bits alternate, high bits nonzero
        frame_a[0] = 32'h96696996;
        frame_a[1] = 32'h00000001;
        for (int i = 2; i < 15; i++)
            frame_a[i] = (32'h5A00_0000 + 32'(i) * 32'h0011_2234) | 32'((i >> 1) & 1);
        x = 32'd0;
        for (int i = 0; i < 15; i++) x = x ^ frame_a[i];
        frame_a[15] = x;
        // frame_b: clearly different contents, class-0 mux bit = 0
        frame_b[0] = 32'h0F1E2D3C;
        frame_b[1] = 32'h80000000;
        for (int i = 2; i < 15; i++)
            frame_b[i] = 32'hC3C3_0000 ^ (32'(i) * 32'h1357_9BDF);
        x = 32'd0;
        for (int i = 0; i < 15; i++) x = x ^ frame_b[i];
        frame_b[15] = x;

        reset = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = 32'd0;
        @(negedge clock);
        armed = 1'b1;
        repeat (2) @(negedge clock);
        // reset state
        check("rst.a.outputs", {a_lut_we, a_sb_we, a_done, a_error, a_busy,
                                a_cfg_ready, a_lut_wdata[26:0]}, 33'd0);
        check("rst.a.state",   33'(a_state_dbg), 33'd0);
        check("rst.b.state",   33'(b_state_dbg), 33'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // 1: good frame, continuous valid
        load_tx(1'b0);
        pulse_start();
        check("t1.ready_after_start", 33'(a_cfg_ready), 33'd1);
        send_words(16, 1'b0);
        watch(14);
        check_good_a("t1");
        check("t1.b.lut_wdata0", s_b_lwd[1], 33'h1_96696996);
        check("t1.b.done@k+9",   33'(s_b_dn[9]),  33'd0);
        check("t1.b.done@k+10",  33'(s_b_dn[10]), 33'd1);

        // 2: checksum bit 0 flipped
        load_tx(1'b0);
        tx[15] = tx[15] ^ 32'd1;
        pulse_start();
        send_words(16, 1'b0);
        watch(14);
        check("t2.error@k+1",  33'(s_a_er[1]), 33'd0);
        check("t2.error@k+2",  33'(s_a_er[2]), 33'd1);
        check("t2.lut_pulses", 33'(count_bits(0, 14)), 33'd0);
        check("t2.sb_pulses",  33'(count_bits(1, 14)), 33'd0);
        check("t2.done",       33'(s_a_dn[13]),  33'd0);
        check("t2.cfg_ready",  33'(s_a_rdy[13]), 33'd0);

        // 3: valid toggled every other cycle
        load_tx(1'b0);
        pulse_start();
        send_words(16, 1'b1);
        watch(14);
        check_good_a("t3");

        // 4: abort after 7 words, then a full new frame
        load_tx(1'b0);
        pulse_start();
        send_words(7, 1'b0);
        pulse_start();
        load_tx(1'b1);
        send_words(16, 1'b0);
        watch(14);
        check("t4.lut_wdata0", s_a_lwd[2], 33'h0_0F1E2D3C);
        check("t4.lut_pulses", 33'(count_bits(0, 14)), 33'd6);
        check("t4.done@k+11",  33'(s_a_dn[11]), 33'd1);

        // 4b: start coincident with the checksum transfer restarts the frame
        load_tx(1'b0);
        pulse_start();
        send_words(15, 1'b0);
        start = 1'b1; cfg_valid = 1'b1; cfg_data = tx[15];
        @(negedge clock);
        start = 1'b0; cfg_valid = 1'b0;
        check("t4b.still_recv", 33'(a_cfg_ready), 33'd1);
        load_tx(1'b1);
        send_words(16, 1'b0);
        watch(14);
        check("t4b.lut_wdata0", s_a_lwd[2], 33'h0_0F1E2D3C);
        check("t4b.done@k+11",  33'(s_a_dn[11]), 33'd1);

        // 5: reset after the third LUT write
        load_tx(1'b0);
        pulse_start();
        send_words(16, 1'b0);
        repeat (4) @(negedge clock);
        check("t5.third_lut_we", 33'(a_lut_we), 33'd1);
        check("t5.third_class",  33'(a_lut_class), 33'd2);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t5.outputs_zero", {a_lut_we, a_sb_we, a_done, a_error, a_busy,
                                  a_cfg_ready, a_lut_wdata[26:0]}, 33'd0);
        check("t5.state_idle",   33'(a_state_dbg), 33'd0);
        watch(12);
        check("t5.no_lut_after", 33'(count_bits(0, 12)), 33'd0);
        check("t5.no_sb_after",  33'(count_bits(1, 12)), 33'd0);
        load_tx(1'b0);
        pulse_start();
        send_words(16, 1'b0);
        watch(14);
        check_good_a("t5r");

        // 6: 15 words then a 16th valid held high; only u_dut_b is judged
        load_tx(1'b0);
        pulse_start();
        send_words(15, 1'b0);
        cfg_valid = 1'b1;
        cfg_data  = 32'hDEADBEEF;
        watch(14);
        cfg_valid = 1'b0;
        check("t6.b.never_ready", 33'(count_bits(3, 14)), 33'd0);
        check("t6.b.lut_pulses",  33'(count_bits(2, 14)), 33'd6);
        check("t6.b.lut_wdata0",  s_b_lwd[2], 33'h1_96696996);
        check("t6.b.done@k+10",   33'(s_b_dn[10]), 33'd0);
        check("t6.b.done@k+11",   33'(s_b_dn[11]), 33'd1);

        repeat (3) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/config_loader.md
# config_loader

Frame-based configuration controller for the add/multiplex/shift fabric. It accepts a 15-word configuration frame over a valid/ready stream, plus an optional XOR checksum word, and stages it in a shadow buffer. Once the frame is verified, it writes the shadow buffer into the fabric's LUT cells and switch boxes in a fixed, atomic write-out sequence. It replaces hierarchical preloading of LUT `mem` and switch-box `configure` registers, and sits between the bitstream source and the fabric.

## Interface
Parameters:
- CHECK_EN, default 1: 1 = a 16th checksum word is required and checked; 0 = the frame is 15 words and no checksum word is consumed.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse that begins a new frame.
- cfg_data  in  32  configuration word.
- cfg_valid  in  1  cfg_data is valid.
- cfg_ready  out  1  loader accepts a word. A word transfers on an edge where cfg_valid & cfg_ready.
- lut_wdata  out  33  {mux control bit, 32-bit LUT}.
- lut_class  out  3  LUT class being written: 0 ADD0, 1 ADD1, 2 ADDC, 3 MUX, 4 MUXS, 5 REGC. All instances of a class are written together.
- lut_we  out  1  LUT write strobe, one cycle per class.
- sb_wdata  out  16  switch-box configuration.
- sb_sel  out  2  0 = SB0, 1 = SB1 and SB2 (broadcast), 2 = SB3.
- sb_we  out  1  switch-box write strobe.
- busy  out  1  high in RECV, CHECK and COMMIT.
- done  out  1  frame committed. Held until the next start or reset.
- error  out  1  checksum mismatch. Held until the next start or reset.

## Operation
- States: IDLE, RECV, CHECK, COMMIT, DONE, ERR.
- Reset value of every output is 0. Reset also clears the state (to IDLE), the word index, the running XOR and the commit index.
- IDLE/DONE/ERR + start → RECV. Entering RECV clears the index, the XOR, done and error.
- RECV:
  - cfg_ready = 1, decoded from the state register only; there is no combinational path from cfg_valid.
  - Each transfer writes shadow[idx] = cfg_data and XORs cfg_data into the running XOR, then increments idx.
- Frame word order, idx 0–14:
  - idx 0 to 11: (LUT, mux) pairs for ADD0, ADD1, ADDC, MUX, MUXS, REGC, in that order.
  - idx 12: SB0 configuration.
  - idx 13: SB1/SB2 configuration.
  - idx 14: SB3 configuration.
- Leaving RECV:
  - CHECK_EN = 1: word 15 is the checksum. Its transfer → CHECK.
  - CHECK_EN = 0: the transfer of word 14 → CHECK.
- CHECK (one cycle):
  - Passes if the checksum equals the XOR of words 0–14 (all 32 bits of every word), or if CHECK_EN = 0. Pass → COMMIT.
  - Mismatch → ERR. ERR sets error = 1 and performs no writes.
- COMMIT: 9 consecutive write cycles, one strobe per cycle.
  - Cycles k = 0 to 5: lut_we = 1, lut_class = k, lut_wdata = {shadow[2k+1][0], shadow[2k]}.
  - Cycles j = 6 to 8: sb_we = 1, sb_sel = j−6, sb_wdata = shadow[12 + (j−6)][15:0].
  - Then → DONE, with done = 1.
- Bits [31:1] of the mux words and bits [31:16] of the SB words are ignored for writing but included in the checksum.
- lut_we and sb_we are never high together. The data and select outputs return to 0 when their strobe is low.
- Boundary conditions:
  - start during RECV: abort. Index and XOR are cleared; already-received words are discarded. No writes occur.
  - start during CHECK or COMMIT: ignored. Commit is atomic unless reset.
  - start coincident with the final transfer: start wins, and the frame restarts.
  - cfg_valid outside RECV: ignored; cfg_ready stays 0.
  - reset mid-COMMIT: outputs are 0 on the next cycle and no further strobes follow. A partially written fabric is permitted; the host reloads it.

## Timing
- start sampled at edge t → cfg_ready = 1 from edge t+1.
- Final transfer at edge k:
  - cfg_ready = 0 from edge k.
  - CHECK occupies the cycle after edge k.
  - lut_we is high after edges k+2 to k+7.
  - sb_we is high after edges k+8 to k+10.
  - done = 1 from edge k+11.
- A checksum fail sets error = 1 from edge k+2.
- Throughput is one word per cycle under continuous valid.
- All outputs are registered or decoded from state; none depend combinationally on inputs.

## Test plan
- Good frame with word0 = 32'h96696996 and word1 = 1, other words distinct, correct checksum → lut_wdata = 33'h1_96696996 on class 0. Six lut_we pulses with classes 0..5 in order, then sb_sel 0, 1, 2. done = 1 exactly 11 cycles after the last transfer.
- Same frame with checksum bit 0 flipped → error = 1 at k+2, zero lut_we/sb_we pulses, done = 0, cfg_ready = 0.
- cfg_valid toggled every other cycle during RECV → identical write sequence to the first case. Words are stored only on transfer edges.
- start after 7 words, then a full new frame → the writes reflect only the new frame, and the first partial frame leaves no trace.
- reset asserted after the 3rd lut_we → all outputs 0 on the next cycle, state IDLE, no further strobes. A fresh start works normally.
- CHECK_EN = 0, 15 words, then a 16th cfg_valid held high → the 16th word is not accepted, and the commit sequence and done timing match the first case.
